// File: rtl/data_memory_mmio_if.sv
// Load/store port of the Mini-MIPS data memory together with the per-channel
// peripheral handshakes. The master side is the processor plus peripherals;
// the slave side is the memory itself.
interface data_memory_mmio_if #(
    parameter int DEPTH_WORDS = 512,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CH      = 1
);
    localparam int ADDR_WIDTH = $clog2(DEPTH_WORDS * 4 + 16 * NUM_CH);

    // Processor load/store port
    logic [ADDR_WIDTH-1:0]        addr;
    logic [DATA_WIDTH-1:0]        data_in;
    logic                         wr_en;
    logic                         rd_en;
    logic [DATA_WIDTH-1:0]        data_out;
    logic                         misaligned;

    // Peripheral channels, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
    logic [NUM_CH*DATA_WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]            in_valid;
    logic [NUM_CH-1:0]            in_ready;
    logic [NUM_CH*DATA_WIDTH-1:0] out_data;
    logic [NUM_CH-1:0]            out_valid;
    logic [NUM_CH-1:0]            out_ready;

    modport master (
        output addr, data_in, wr_en, rd_en, in_data, in_valid, out_ready,
        input  data_out, misaligned, in_ready, out_data, out_valid
    );

    modport slave (
        input  addr, data_in, wr_en, rd_en, in_data, in_valid, out_ready,
        output data_out, misaligned, in_ready, out_data, out_valid
    );
endinterface

// File: rtl/data_memory_mmio.sv
// Mini-MIPS data memory: word RAM with combinational read, followed by an
// MMIO window of NUM_CH channels (16 bytes each) carrying an input holding
// register, an output register and sticky overrun/dropped status bits.
module data_memory_mmio #(
    parameter int DEPTH_WORDS = 512,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CH      = 1
) (
    input logic               clk,
    input logic               rst,
    data_memory_mmio_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(DEPTH_WORDS * 4 + 16 * NUM_CH);
    localparam int RAM_AW     = $clog2(DEPTH_WORDS);
    localparam int WORD_AW    = ADDR_WIDTH - 2;
    localparam int CH_SEL_W   = ADDR_WIDTH - 4;
    // MMIO base expressed as a word address (byte base is DEPTH_WORDS*4)
    localparam logic [WORD_AW-1:0] MMIO_BASE_W = WORD_AW'(DEPTH_WORDS);

    localparam logic [1:0] REG_IN_DATA  = 2'd0;
    localparam logic [1:0] REG_IN_STAT  = 2'd1;
    localparam logic [1:0] REG_OUT_DATA = 2'd2;
    localparam logic [1:0] REG_OUT_STAT = 2'd3;

    logic                  aligned;
    logic                  is_ram;
    logic                  is_mmio;
    logic [WORD_AW-1:0]    mmio_woff;
    logic [CH_SEL_W-1:0]   ch_sel;
    logic [1:0]            reg_sel;
    logic [RAM_AW-1:0]     ram_idx;
    logic [DATA_WIDTH-1:0] mmio_rd;
    logic [DATA_WIDTH-1:0] ch_rd [NUM_CH];
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // Address decode: everything works on word addresses, the low two bits
    // only feed the alignment check.
    assign aligned   = (bus.addr[1:0] == 2'b00);
    assign is_ram    = (bus.addr[ADDR_WIDTH-1:2] < MMIO_BASE_W);
    assign mmio_woff = bus.addr[ADDR_WIDTH-1:2] - MMIO_BASE_W;
    assign ch_sel    = mmio_woff[WORD_AW-1:2];
    assign reg_sel   = mmio_woff[1:0];
    assign is_mmio   = !is_ram && (ch_sel < CH_SEL_W'(NUM_CH));
    assign ram_idx   = bus.addr[RAM_AW+1:2];

    assign bus.misaligned = !aligned && (bus.wr_en || bus.rd_en);

    // RAM store port; contents are deliberately neither reset nor initialised
    always_ff @(posedge clk) begin
        if (!rst && bus.wr_en && aligned && is_ram) begin
            mem[ram_idx] <= bus.data_in;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic                  hit;
        logic                  rd_in_data;
        logic                  wr_in_stat;
        logic                  wr_out_data;
        logic                  wr_out_stat;
        logic                  in_hs;
        logic                  out_hs;
        logic                  full_reg, full_next;
        logic                  overrun_reg, overrun_next;
        logic                  pending_reg, pending_next;
        logic                  dropped_reg, dropped_next;
        logic [DATA_WIDTH-1:0] hold_reg, hold_next;
        logic [DATA_WIDTH-1:0] out_reg, out_next;

        assign hit         = aligned && is_mmio && (ch_sel == CH_SEL_W'(gi));
        assign rd_in_data  = bus.rd_en && hit && (reg_sel == REG_IN_DATA);
        assign wr_in_stat  = bus.wr_en && hit && (reg_sel == REG_IN_STAT);
        assign wr_out_data = bus.wr_en && hit && (reg_sel == REG_OUT_DATA);
        assign wr_out_stat = bus.wr_en && hit && (reg_sel == REG_OUT_STAT);
        assign in_hs       = bus.in_valid[gi] && !full_reg;
        assign out_hs      = pending_reg && bus.out_ready[gi];

        assign bus.in_ready[gi]  = !full_reg;
        assign bus.out_valid[gi] = pending_reg;
        assign bus.out_data[gi*DATA_WIDTH +: DATA_WIDTH] = out_reg;

        // Input side: accept while empty, pop on a load of IN_DATA, flag a
        // load of an empty holding register as overrun (set beats W1C).
        always_comb begin
            full_next    = full_reg;
            hold_next    = hold_reg;
            overrun_next = overrun_reg;
            if (in_hs) begin
                full_next = 1'b1;
                hold_next = bus.in_data[gi*DATA_WIDTH +: DATA_WIDTH];
            end else if (rd_in_data && full_reg) begin
                full_next = 1'b0;
            end
            if (rd_in_data && !full_reg) begin
                overrun_next = 1'b1;
            end else if (wr_in_stat && bus.data_in[1]) begin
                overrun_next = 1'b0;
            end
        end

        // Output side: a store lands if the register is free or is being
        // drained this very cycle; otherwise it is dropped and flagged.
        always_comb begin
            pending_next = pending_reg;
            out_next     = out_reg;
            dropped_next = dropped_reg;
            if (wr_out_data) begin
                if (!pending_reg || bus.out_ready[gi]) begin
                    out_next     = bus.data_in;
                    pending_next = 1'b1;
                end else begin
                    dropped_next = 1'b1;
                end
            end else if (out_hs) begin
                pending_next = 1'b0;
            end
            if (wr_out_data && pending_reg && !bus.out_ready[gi]) begin
                dropped_next = 1'b1;
            end else if (wr_out_stat && bus.data_in[1]) begin
                dropped_next = 1'b0;
            end
        end

        // Channel state register with synchronous reset
        always_ff @(posedge clk) begin
            if (rst) begin
                full_reg    <= 1'b0;
                overrun_reg <= 1'b0;
                pending_reg <= 1'b0;
                dropped_reg <= 1'b0;
                hold_reg    <= '0;
                out_reg     <= '0;
            end else begin
                full_reg    <= full_next;
                overrun_reg <= overrun_next;
                pending_reg <= pending_next;
                dropped_reg <= dropped_next;
                hold_reg    <= hold_next;
                out_reg     <= out_next;
            end
        end

        // Per-channel register read mux
        always_comb begin
            case (reg_sel)
                REG_IN_DATA:  ch_rd[gi] = hold_reg;
                REG_IN_STAT:  ch_rd[gi] = {{(DATA_WIDTH-2){1'b0}}, overrun_reg, full_reg};
                REG_OUT_DATA: ch_rd[gi] = out_reg;
                default:      ch_rd[gi] = {{(DATA_WIDTH-2){1'b0}}, dropped_reg, pending_reg};
            endcase
        end
    end

    // Load path: combinational, zero for misaligned or unmapped addresses
    always_comb begin
        mmio_rd = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_sel == CH_SEL_W'(k)) begin
                mmio_rd = ch_rd[k];
            end
        end
        if (!aligned) begin
            bus.data_out = '0;
        end else if (is_ram) begin
            bus.data_out = mem[ram_idx];
        end else if (is_mmio) begin
            bus.data_out = mmio_rd;
        end else begin
            bus.data_out = '0;
        end
    end
endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed bench for data_memory_mmio with two channels (MMIO base 0x800).
module tb_data_memory_mmio;
    localparam int DW = 32;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    data_memory_mmio_if #(.DEPTH_WORDS(512), .DATA_WIDTH(DW), .NUM_CH(2)) bus ();

    data_memory_mmio #(.DEPTH_WORDS(512), .DATA_WIDTH(DW), .NUM_CH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1-2 time units after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.data_in = '0;
        bus.addr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.in_valid = '0;
        bus.out_ready = '0;
        bus.in_data = '0;
        repeat (2) cyc();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 2'b11) begin errors++; $display("FAIL rst_in_ready: got %b exp 11", bus.in_ready); end
        else $display("ok rst_in_ready");
        checks++;
        if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL rst_out_valid: got %b exp 00", bus.out_valid); end
        else $display("ok rst_out_valid");
        bus.addr = 12'h804;
        #1;
        checks++;
        if (bus.data_out !== 32'h0) begin errors++; $display("FAIL rst_in_stat: got %h exp 0", bus.data_out); end
        else $display("ok rst_in_stat");
    endtask

    task automatic test_ram();
        bus.addr = 12'h010; bus.data_in = 32'hDEADBEEF; bus.wr_en = 1'b1;
        cyc();
        bus.wr_en = 1'b0; bus.rd_en = 1'b1;
        #1;
        checks++;
        if (bus.data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_load: got %h exp deadbeef", bus.data_out); end
        else $display("ok ram_load");
        bus.rd_en = 1'b0; bus.addr = 12'h011; bus.data_in = 32'h12345678; bus.wr_en = 1'b1;
        #1;
        checks++;
        if (bus.misaligned !== 1'b1) begin errors++; $display("FAIL misaligned_flag: got %b exp 1", bus.misaligned); end
        else $display("ok misaligned_flag");
        checks++;
        if (bus.data_out !== 32'h0) begin errors++; $display("FAIL misaligned_data: got %h exp 0", bus.data_out); end
        else $display("ok misaligned_data");
        cyc();
        bus.wr_en = 1'b0; bus.rd_en = 1'b1; bus.addr = 12'h010;
        #1;
        checks++;
        if (bus.misaligned !== 1'b0) begin errors++; $display("FAIL aligned_flag: got %b exp 0", bus.misaligned); end
        else $display("ok aligned_flag");
        checks++;
        if (bus.data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_after_misaligned: got %h exp deadbeef", bus.data_out); end
        else $display("ok ram_after_misaligned");
        bus.addr = 12'h014; bus.rd_en = 1'b0; bus.wr_en = 1'b1; bus.data_in = 32'h0BADF00D;
        cyc();
        bus.wr_en = 1'b0;
        #1;
        checks++;
        if (bus.data_out !== 32'h0BADF00D) begin errors++; $display("FAIL ram_word5: got %h exp 0badf00d", bus.data_out); end
        else $display("ok ram_word5");
        idle();
    endtask

    task automatic test_input();
        bus.in_valid[0] = 1'b1; bus.in_data[31:0] = 32'h55;
        cyc();
        bus.in_valid[0] = 1'b0; bus.addr = 12'h804;
        #1;
        checks++;
        if (bus.in_ready !== 2'b10) begin errors++; $display("FAIL in_full_ready: got %b exp 10", bus.in_ready); end
        else $display("ok in_full_ready");
        checks++;
        if (bus.data_out !== 32'h1) begin errors++; $display("FAIL in_stat_full: got %h exp 1", bus.data_out); end
        else $display("ok in_stat_full");
        bus.addr = 12'h800; bus.rd_en = 1'b1;
        #1;
        checks++;
        if (bus.data_out !== 32'h55) begin errors++; $display("FAIL in_pop_data: got %h exp 55", bus.data_out); end
        else $display("ok in_pop_data");
        cyc();
        bus.rd_en = 1'b0; bus.addr = 12'h804;
        #1;
        checks++;
        if (bus.data_out !== 32'h0) begin errors++; $display("FAIL in_stat_popped: got %h exp 0", bus.data_out); end
        else $display("ok in_stat_popped");
        checks++;
        if (bus.in_ready !== 2'b11) begin errors++; $display("FAIL in_ready_popped: got %b exp 11", bus.in_ready); end
        else $display("ok in_ready_popped");
        idle();
    endtask

    task automatic test_back_to_back();
        bus.in_valid[0] = 1'b1; bus.in_data[31:0] = 32'h66;
        cyc();
        bus.in_data[31:0] = 32'h77; bus.addr = 12'h800; bus.rd_en = 1'b1;
        #1;
        checks++;
        if (bus.data_out !== 32'h66) begin errors++; $display("FAIL b2b_first: got %h exp 66", bus.data_out); end
        else $display("ok b2b_first");
        cyc();
        bus.rd_en = 1'b0;
        #1;
        checks++;
        if (bus.in_ready[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_pop: got %b exp 1", bus.in_ready[0]); end
        else $display("ok b2b_ready_after_pop");
        cyc();
        bus.in_valid[0] = 1'b0;
        #1;
        checks++;
        if (bus.data_out !== 32'h77) begin errors++; $display("FAIL b2b_second: got %h exp 77", bus.data_out); end
        else $display("ok b2b_second");
        checks++;
        if (bus.in_ready[0] !== 1'b0) begin errors++; $display("FAIL b2b_full_again: got %b exp 0", bus.in_ready[0]); end
        else $display("ok b2b_full_again");
        bus.rd_en = 1'b1;
        cyc();
        idle();
    endtask

    task automatic test_overrun();
        bus.addr = 12'h800; bus.rd_en = 1'b1;
        #1;
        checks++;
        if (bus.data_out !== 32'h77) begin errors++; $display("FAIL overrun_stale: got %h exp 77", bus.data_out); end
        else $display("ok overrun_stale");
        cyc();
        bus.rd_en = 1'b0; bus.addr = 12'h804;
        #1;
        checks++;
        if (bus.data_out !== 32'h2) begin errors++; $display("FAIL overrun_set: got %h exp 2", bus.data_out); end
        else $display("ok overrun_set");
        checks++;
        if (bus.in_ready[0] !== 1'b1) begin errors++; $display("FAIL overrun_no_pop: got %b exp 1", bus.in_ready[0]); end
        else $display("ok overrun_no_pop");
        bus.wr_en = 1'b1; bus.data_in = 32'h1;
        cyc();
        bus.wr_en = 1'b0;
        #1;
        checks++;
        if (bus.data_out !== 32'h2) begin errors++; $display("FAIL overrun_w1c_bit0: got %h exp 2", bus.data_out); end
        else $display("ok overrun_w1c_bit0");
        bus.wr_en = 1'b1; bus.data_in = 32'h2;
        cyc();
        bus.wr_en = 1'b0;
        #1;
        checks++;
        if (bus.data_out !== 32'h0) begin errors++; $display("FAIL overrun_w1c: got %h exp 0", bus.data_out); end
        else $display("ok overrun_w1c");
        idle();
    endtask

    task automatic test_output();
        bus.out_ready = '0;
        bus.addr = 12'h808; bus.data_in = 32'hA1; bus.wr_en = 1'b1;
        cyc();
        bus.wr_en = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 2'b01) begin errors++; $display("FAIL out_valid_set: got %b exp 01", bus.out_valid); end
        else $display("ok out_valid_set");
        checks++;
        if (bus.out_data[31:0] !== 32'hA1) begin errors++; $display("FAIL out_data_a1: got %h exp a1", bus.out_data[31:0]); end
        else $display("ok out_data_a1");
        checks++;
        if (bus.data_out !== 32'hA1) begin errors++; $display("FAIL out_readback: got %h exp a1", bus.data_out); end
        else $display("ok out_readback");
        bus.data_in = 32'hB2; bus.wr_en = 1'b1;
        cyc();
        bus.wr_en = 1'b0; bus.addr = 12'h80C;
        #1;
        checks++;
        if (bus.data_out !== 32'h3) begin errors++; $display("FAIL out_dropped_stat: got %h exp 3", bus.data_out); end
        else $display("ok out_dropped_stat");
        checks++;
        if (bus.out_data[31:0] !== 32'hA1) begin errors++; $display("FAIL out_dropped_data: got %h exp a1", bus.out_data[31:0]); end
        else $display("ok out_dropped_data");
        bus.out_ready[0] = 1'b1;
        cyc();
        bus.out_ready[0] = 1'b0;
        #1;
        checks++;
        if (bus.data_out !== 32'h2) begin errors++; $display("FAIL out_drained_stat: got %h exp 2", bus.data_out); end
        else $display("ok out_drained_stat");
        checks++;
        if (bus.out_valid[0] !== 1'b0) begin errors++; $display("FAIL out_drained_valid: got %b exp 0", bus.out_valid[0]); end
        else $display("ok out_drained_valid");
        bus.wr_en = 1'b1; bus.data_in = 32'h2;
        cyc();
        bus.wr_en = 1'b0;
        #1;
        checks++;
        if (bus.data_out !== 32'h0) begin errors++; $display("FAIL out_w1c: got %h exp 0", bus.data_out); end
        else $display("ok out_w1c");
        idle();
    endtask

    task automatic test_write_while_accept();
        bus.addr = 12'h808; bus.data_in = 32'hA1; bus.wr_en = 1'b1;
        cyc();
        bus.data_in = 32'hC3; bus.out_ready[0] = 1'b1;
        cyc();
        bus.wr_en = 1'b0; bus.out_ready[0] = 1'b0; bus.addr = 12'h80C;
        #1;
        checks++;
        if (bus.out_valid[0] !== 1'b1) begin errors++; $display("FAIL wwa_valid: got %b exp 1", bus.out_valid[0]); end
        else $display("ok wwa_valid");
        checks++;
        if (bus.out_data[31:0] !== 32'hC3) begin errors++; $display("FAIL wwa_data: got %h exp c3", bus.out_data[31:0]); end
        else $display("ok wwa_data");
        checks++;
        if (bus.data_out !== 32'h1) begin errors++; $display("FAIL wwa_stat: got %h exp 1", bus.data_out); end
        else $display("ok wwa_stat");
        bus.out_ready[0] = 1'b1;
        cyc();
        bus.out_ready[0] = 1'b0;
        idle();
    endtask

    task automatic test_ch1_and_reset();
        bus.in_valid[1] = 1'b1; bus.in_data[63:32] = 32'h99;
        bus.addr = 12'h818; bus.data_in = 32'hBB; bus.wr_en = 1'b1;
        cyc();
        bus.in_valid[1] = 1'b0; bus.wr_en = 1'b0; bus.addr = 12'h814;
        #1;
        checks++;
        if (bus.in_ready !== 2'b01) begin errors++; $display("FAIL ch1_in_ready: got %b exp 01", bus.in_ready); end
        else $display("ok ch1_in_ready");
        checks++;
        if (bus.data_out !== 32'h1) begin errors++; $display("FAIL ch1_in_stat: got %h exp 1", bus.data_out); end
        else $display("ok ch1_in_stat");
        checks++;
        if (bus.out_valid !== 2'b10 || bus.out_data[63:32] !== 32'hBB) begin
            errors++; $display("FAIL ch1_out: got valid %b data %h exp 10 bb", bus.out_valid, bus.out_data[63:32]);
        end else $display("ok ch1_out");
        bus.addr = 12'h804;
        #1;
        checks++;
        if (bus.data_out !== 32'h0) begin errors++; $display("FAIL ch0_in_stat_iso: got %h exp 0", bus.data_out); end
        else $display("ok ch0_in_stat_iso");
        bus.addr = 12'h80C;
        #1;
        checks++;
        if (bus.data_out !== 32'h0) begin errors++; $display("FAIL ch0_out_stat_iso: got %h exp 0", bus.data_out); end
        else $display("ok ch0_out_stat_iso");
        bus.addr = 12'h820; bus.data_in = 32'hFFFF_FFFF; bus.wr_en = 1'b1;
        cyc();
        bus.wr_en = 1'b0;
        #1;
        checks++;
        if (bus.data_out !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h exp 0", bus.data_out); end
        else $display("ok unmapped_read");
        // reset with ch1 full and pending, plus a store and an offered word
        rst = 1'b1;
        bus.addr = 12'h010; bus.data_in = 32'h1111; bus.wr_en = 1'b1;
        bus.in_valid = 2'b11; bus.in_data = {32'hAAAA, 32'hBBBB};
        cyc();
        rst = 1'b0; bus.wr_en = 1'b0; bus.in_valid = 2'b00; bus.addr = 12'h814;
        #1;
        checks++;
        if (bus.in_ready !== 2'b11 || bus.out_valid !== 2'b00) begin
            errors++; $display("FAIL rst2_hs: got ready %b valid %b exp 11 00", bus.in_ready, bus.out_valid);
        end else $display("ok rst2_hs");
        checks++;
        if (bus.data_out !== 32'h0) begin errors++; $display("FAIL rst2_ch1_in_stat: got %h exp 0", bus.data_out); end
        else $display("ok rst2_ch1_in_stat");
        bus.addr = 12'h81C;
        #1;
        checks++;
        if (bus.data_out !== 32'h0) begin errors++; $display("FAIL rst2_ch1_out_stat: got %h exp 0", bus.data_out); end
        else $display("ok rst2_ch1_out_stat");
        checks++;
        if (bus.out_data !== 64'h0) begin errors++; $display("FAIL rst2_out_data: got %h exp 0", bus.out_data); end
        else $display("ok rst2_out_data");
        bus.addr = 12'h810;
        #1;
        checks++;
        if (bus.data_out !== 32'h0) begin errors++; $display("FAIL rst2_holding: got %h exp 0", bus.data_out); end
        else $display("ok rst2_holding");
        bus.addr = 12'h010;
        #1;
        checks++;
        if (bus.data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL rst2_ram_kept: got %h exp deadbeef", bus.data_out); end
        else $display("ok rst2_ram_kept");
        idle();
    endtask

    initial begin
        test_reset();
        test_ram();
        test_input();
        test_back_to_back();
        test_overrun();
        test_output();
        test_write_while_accept();
        test_ch1_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
